gb_link_ctrl: RTL
=================

Name: gb_link_ctrl

Overview:
Game Boy serial link transfer controller (SB/SC register pair plus shift sequencer). It sequences an 8-bit exchange over the link cable. In internal-clock mode it generates the serial clock from a divider tick. In external-clock mode it follows an edge-detected remote clock. On completion it raises a one-cycle interrupt pulse toward the CPU interrupt logic.

Parameters:
WIDTH, 8, transfer/shift register width in bits
CNT_W, 3, bit-counter width; must equal log2(WIDTH)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
tick  input  1  internal serial half-period enable, one clk cycle wide
wr_sb  input  1  CPU write strobe, SB (data) register
wr_sc  input  1  CPU write strobe, SC (control) register
din  input  WIDTH  CPU write data; for SC writes, bit7 = start, bit0 = internal clock
sclk_in  input  1  remote serial clock, already synchronised to clk
sin  input  1  serial data in, already synchronised to clk
sb  output  WIDTH  shift/data register, CPU-readable
sc_start  output  1  transfer-in-progress flag (SC bit7)
sc_int_clk  output  1  clock-source flag (SC bit0)
sclk_out  output  1  serial clock driven to cable; idles high
sout  output  1  serial data out
irq  output  1  transfer-complete pulse, exactly one clk cycle

Behaviour:
- Reset values: sb=0, sc_start=0, sc_int_clk=0, sclk_out=1, sout=1, irq=0, bit counter=0, state=IDLE, sclk_in history=1.
- All outputs are registered. irq defaults to 0 every cycle unless set by completion.
- States: IDLE, LOW (clock low, bit presented), HIGH (clock high, waiting for next falling phase).
- wr_sc: sc_int_clk<=din[0] and sc_start<=din[7] in every state.
  - din[7]=1: bit counter<=0; state<=HIGH (await first falling phase); sclk_out<=1.
  - din[7]=0: abort to IDLE; counter<=0; sclk_out<=1; sb retains the partially shifted value; no irq.
- Falling phase: on tick when sc_int_clk=1, or on sclk_in 1->0 when sc_int_clk=0, while in HIGH with sc_start=1:
  - sout<=sb[WIDTH-1]; state<=LOW.
  - Internal mode only: sclk_out<=0.
- Rising phase: on tick when sc_int_clk=1, or on sclk_in 0->1 when sc_int_clk=0, while in LOW:
  - sb<={sb[WIDTH-2:0], sin}; counter<=counter+1.
  - Internal mode only: sclk_out<=1.
  - If counter was WIDTH-1: state<=IDLE, sc_start<=0, irq<=1, counter wraps to 0. All of these update at the same edge as the final shift.
  - Otherwise: state<=HIGH.
- External mode: sclk_out is held at 1. tick is ignored.
- Internal mode: sclk_in edges are ignored. The sclk_in history register still updates every cycle.
- Internal transfer timing: 2*WIDTH ticks from start to irq. The first tick after start is a falling phase.
- wr_sb: sb<=din in any state.
  - wr_sb coincident with a rising-phase shift: wr_sb wins, but counter still increments.
  - wr_sb coincident with the completion shift: wr_sb wins; sc_start, irq and state still update as for completion.
- wr_sc coincident with any phase event: wr_sc wins; the phase event is dropped.
- wr_sb and wr_sc in the same cycle: both take effect.
- IDLE: tick and sclk_in edges have no effect; sout holds its last value.
- Reset asserted mid-transfer: all state returns to reset values on that edge. No irq is generated.

Test Plan:
- Internal mode, sout looped to sin: wr_sb 0xA5, then wr_sc 0x81, 16 ticks.
  -> sout sequence 1,0,1,0,0,1,0,1 on falling phases; 8 low pulses on sclk_out.
  -> After tick 16: sb=0xA5, sc_start=0, irq high exactly one cycle.
- Internal mode, sin=0, sb=0xFF, wr_sc 0x81, ticks spaced 5 clk apart.
  -> sb=0x00 after 16 ticks; sclk_out=1 afterwards. Extra ticks cause no change and no irq.
- External mode: wr_sc 0x80, sin=1, sb=0x3C, ticks toggling throughout, 8 sclk_in low/high pulses.
  -> sb=0xFF; sclk_out constant 1; irq one pulse after the 8th rising edge. Ticks have no effect.
- Abort: internal transfer of 0xF0 with sin=0; after 3 rising phases, wr_sc 0x01.
  -> sb=0x80, sc_start=0, state IDLE, no irq.
  -> Restart with wr_sc 0x81: 16 ticks later irq fires, counter restarted from 0.
- Collision: wr_sb 0x5A in the same cycle as the 4th rising phase.
  -> sb=0x5A at that edge; transfer still completes after 4 further rising phases.
  -> wr_sc issued in the same cycle as a tick: tick ignored.
- Reset mid-transfer after 5 bits.
  -> All outputs at reset values; sclk_out=1, sout=1, irq never pulses. A subsequent 0x81 transfer completes normally.

Source files
------------

// File: rtl/gb_link_ctrl.sv
// Game Boy serial link controller: SB/SC registers plus the bit sequencer that
// shifts one byte out/in per transfer, on an internal tick or a remote clock.
module gb_link_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr_sb,
  input  logic             wr_sc,
  input  logic [WIDTH-1:0] din,
  input  logic             sclk_in,
  input  logic             sin,
  output logic [WIDTH-1:0] sb,
  output logic             sc_start,
  output logic             sc_int_clk,
  output logic             sclk_out,
  output logic             sout,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sclk_hist;

  logic [WIDTH-1:0] sb_n;
  logic             sc_start_n, sc_int_clk_n, sclk_out_n, sout_n, irq_n;

  logic fall_ev, rise_ev, phase_fall, phase_rise, last_bit;

  // Phase source: divider tick in internal mode, remote clock edges otherwise.
  // CPU strobes are single-cycle and always accepted; a control write in the
  // same cycle as a phase event takes priority and the event is dropped.
  always_comb begin
    fall_ev    = sc_int_clk ? tick : (sclk_hist & ~sclk_in);
    rise_ev    = sc_int_clk ? tick : (~sclk_hist & sclk_in);
    phase_fall = (state == HIGH) && sc_start && fall_ev && !wr_sc;
    phase_rise = (state == LOW) && rise_ev && !wr_sc;
    last_bit   = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (wr_sc)           state_n = din[7] ? HIGH : IDLE;
    else if (phase_fall) state_n = LOW;
    else if (phase_rise) state_n = last_bit ? IDLE : HIGH;
  end

  always_comb begin
    sb_n         = sb;
    cnt_n        = cnt;
    sc_start_n   = sc_start;
    sc_int_clk_n = sc_int_clk;
    sclk_out_n   = sclk_out;
    sout_n       = sout;
    irq_n        = 1'b0;
    if (phase_fall) begin
      sout_n = sb[WIDTH-1];
      if (sc_int_clk) sclk_out_n = 1'b0;
    end
    if (phase_rise) begin
      sb_n  = {sb[WIDTH-2:0], sin};
      cnt_n = cnt + 1'b1;
      if (sc_int_clk) sclk_out_n = 1'b1;
      if (last_bit) begin
        sc_start_n = 1'b0;
        irq_n      = 1'b1;
      end
    end
    if (wr_sc) begin
      sc_start_n   = din[7];
      sc_int_clk_n = din[0];
      cnt_n        = '0;
      sclk_out_n   = 1'b1;
    end
    // A data write overrides the shifted value but not the bit count.
    if (wr_sb) sb_n = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb         <= '0;
      cnt        <= '0;
      sc_start   <= 1'b0;
      sc_int_clk <= 1'b0;
      sclk_out   <= 1'b1;
      sout       <= 1'b1;
      irq        <= 1'b0;
      sclk_hist  <= 1'b1;
    end else begin
      sb         <= sb_n;
      cnt        <= cnt_n;
      sc_start   <= sc_start_n;
      sc_int_clk <= sc_int_clk_n;
      sclk_out   <= sclk_out_n;
      sout       <= sout_n;
      irq        <= irq_n;
      sclk_hist  <= sclk_in;
    end
  end

endmodule
